save_ram_arbiter: RTL and testbench
===================================

# save_ram_arbiter

Shares the single-port cartridge save RAM port (bk_wr / bk_addr / bk_data / bk_q) between three clients: the bridge save loader (writes), the bridge save unloader (reads) and the RTC restore sequencer (writes). It sits in clk_sys between those clients and the GB core's backup-RAM port. It serialises their accesses with a req/ack handshake and applies the save-region bound. Accesses at or beyond the save size complete without touching RAM.

## Interface
- READ_LATENCY, 2: clk_sys cycles from bk_addr presented to bk_q valid (1..7)
- WR_HOLD, 3: cycles bk_wr is held high per write (1..7)
- clk_sys  in  1  system clock, sole clock
- reset_n  in  1  synchronous, active-low reset
- save_size_bytes  in  18  save region size in bytes; sampled at grant
- rtc_req  in  1  RTC write request, held until rtc_ack
- rtc_addr  in  18  RTC byte address
- rtc_data  in  16  RTC write word
- rtc_ack  out  1  one-cycle completion pulse
- ld_req  in  1  loader write request, held until ld_ack
- ld_addr  in  18  loader byte address
- ld_data  in  16  loader write word
- ld_ack  out  1  one-cycle completion pulse
- ul_req  in  1  unloader read request, held until ul_ack
- ul_addr  in  18  unloader byte address
- ul_ack  out  1  one-cycle completion pulse, coincident with ul_rvalid
- ul_rvalid  out  1  ul_rdata valid this cycle
- ul_rdata  out  16  read word; held until the next read completes
- bk_wr  out  1  RAM write enable
- bk_addr  out  17  RAM word address, byte address [17:1]
- bk_data  out  16  RAM write data
- bk_q  in  16  RAM read data
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, WRITE, READ, DONE.
- IDLE, one or more reqs high: grant one client and latch its addr, data and type.
  - Priority: rtc highest.
  - ld vs ul: round-robin via a last_served bit. After reset ld wins the first tie.
  - Write grant, addr < save_size_bytes: go to WRITE.
  - Read grant, addr < save_size_bytes: go to READ.
  - Any grant with addr >= save_size_bytes: go straight to DONE. No bk_wr is issued. A read returns 16'hFFFF.
- WRITE: bk_wr=1, bk_addr and bk_data driven from the latched values. Lasts WR_HOLD cycles, then DONE.
- READ: bk_addr driven for READ_LATENCY+1 cycles. bk_q is captured into ul_rdata at the end of the last cycle. Then DONE.
- DONE: the granted client's ack=1 for exactly one cycle; ul_rvalid=1 for reads. Next state is IDLE.
- Requester rule: drop req on the edge where ack is sampled high. A req still high in the following IDLE cycle is treated as a new request.
- bk_addr and bk_data hold their last values outside WRITE/READ. bk_wr=0 outside WRITE.
- save_size_bytes = 0: every access is out of range. Writes are dropped and reads return 16'hFFFF.
- Odd byte address: bit 0 is ignored.

## Timing
- Reset (reset_n=0 at an edge) forces:
  - state IDLE, last_served=ul;
  - all acks, ul_rvalid, bk_wr and busy = 0;
  - bk_addr, bk_data, ul_rdata = 0.
- An operation interrupted by reset is abandoned; no ack is issued for it.
- Request seen in IDLE at cycle T:
  - In-range write: bk_wr high in cycles T+1..T+WR_HOLD; ack at T+WR_HOLD+1; IDLE at T+WR_HOLD+2.
  - In-range read: bk_addr valid from T+1; bk_q sampled in cycle T+1+READ_LATENCY; ack/rvalid at T+2+READ_LATENCY.
  - Out-of-range access: ack at T+1.
- Back-to-back throughput, one client, in-range: write one per WR_HOLD+2 cycles; read one per READ_LATENCY+3 cycles.
- Simultaneous reqs in IDLE: exactly one grant. The others wait with no loss and no duplication.
- All outputs are registered (Moore). No combinational path from any req to any ack.

## Test plan
- Reset mid-WRITE: assert reset_n=0 in the 2nd bk_wr cycle. Required: bk_wr=0 and busy=0 next cycle, ld_ack never pulses, and the next ld request is serviced normally.
- Loader write: save_size=8192, ld_addr=0x0102, data 0xBEEF, WR_HOLD=3. Required: bk_wr high 3 cycles with bk_addr=0x081 and bk_data=0xBEEF, then a single ld_ack.
- Unloader read: RAM model with latency 2 returns 0x1234 at word 0x010, ul_addr=0x0020. Required: ul_ack=ul_rvalid=1 at T+4, ul_rdata=0x1234 and held afterwards.
- Out of range: save_size=512, ul_addr=0x0200 and ld_addr=0x0300. Required: each acks at T+1 with no bk_wr; ul_rdata=0xFFFF.
- Contention: rtc, ld and ul asserted together and held, each re-requesting after its ack. Required grant order is rtc, then ld, then ul, then alternating ld/ul while rtc stays idle. No ack is duplicated or lost.
- save_size=0: 5 rtc writes at byte addresses 0..8. Required: 5 rtc_acks, each at T+1, and zero bk_wr pulses.

Source files
------------

// File: rtl/save_ram_arbiter.sv
// Arbitrates the cartridge save-RAM port between the RTC restorer, save loader and save unloader.
// Fixed RTC priority, loader/unloader round-robin, out-of-range accesses complete without touching RAM.
module save_ram_arbiter #(
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned WR_HOLD      = 3
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [17:0] save_size_bytes,
  input  logic        rtc_req,
  input  logic [17:0] rtc_addr,
  input  logic [15:0] rtc_data,
  output logic        rtc_ack,
  input  logic        ld_req,
  input  logic [17:0] ld_addr,
  input  logic [15:0] ld_data,
  output logic        ld_ack,
  input  logic        ul_req,
  input  logic [17:0] ul_addr,
  output logic        ul_ack,
  output logic        ul_rvalid,
  output logic [15:0] ul_rdata,
  output logic        bk_wr,
  output logic [16:0] bk_addr,
  output logic [15:0] bk_data,
  input  logic [15:0] bk_q,
  output logic        busy
);

  localparam int unsigned AW = 18;
  localparam int unsigned DW = 16;
  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DONE} state_t;
  typedef enum logic [1:0] {C_RTC, C_LD, C_UL} client_t;

  state_t          state_q;
  client_t         client_q;
  logic            last_ul_q;
  logic [CW-1:0]   cnt_q;
  logic            rtc_ack_q;
  logic            ld_ack_q;
  logic            ul_ack_q;
  logic            ul_rvalid_q;
  logic [DW-1:0]   ul_rdata_q;
  logic            bk_wr_q;
  logic [AW-2:0]   bk_addr_q;
  logic [DW-1:0]   bk_data_q;
  logic            busy_q;

  logic            gnt_valid_c;
  client_t         gnt_client_c;
  logic [AW-1:0]   gnt_addr_c;
  logic [DW-1:0]   gnt_data_c;
  logic            gnt_in_range_c;
  logic            done_next_c;
  client_t         done_client_c;

  // Grant selection: RTC first, then loader/unloader alternating on ties
  always_comb begin
    gnt_valid_c  = rtc_req | ld_req | ul_req;
    gnt_client_c = C_RTC;
    gnt_addr_c   = rtc_addr;
    gnt_data_c   = rtc_data;
    if (rtc_req) begin
      gnt_client_c = C_RTC;
    end else if (ld_req && (!ul_req || last_ul_q)) begin
      gnt_client_c = C_LD;
      gnt_addr_c   = ld_addr;
      gnt_data_c   = ld_data;
    end else if (ul_req) begin
      gnt_client_c = C_UL;
      gnt_addr_c   = ul_addr;
    end
    gnt_in_range_c = (gnt_addr_c < save_size_bytes);
  end

  // Detect the edge that enters DONE so the acks come out registered
  always_comb begin
    done_next_c   = 1'b0;
    done_client_c = client_q;
    unique case (state_q)
      S_IDLE: begin
        done_next_c   = gnt_valid_c && !gnt_in_range_c;
        done_client_c = gnt_client_c;
      end
      S_WRITE: done_next_c = (cnt_q == CW'(WR_HOLD - 1));
      S_READ:  done_next_c = (cnt_q == CW'(READ_LATENCY));
      default: done_next_c = 1'b0;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      client_q    <= C_RTC;
      last_ul_q   <= 1'b1;
      cnt_q       <= '0;
      rtc_ack_q   <= 1'b0;
      ld_ack_q    <= 1'b0;
      ul_ack_q    <= 1'b0;
      ul_rvalid_q <= 1'b0;
      ul_rdata_q  <= '0;
      bk_wr_q     <= 1'b0;
      bk_addr_q   <= '0;
      bk_data_q   <= '0;
      busy_q      <= 1'b0;
    end else begin
      rtc_ack_q   <= done_next_c && (done_client_c == C_RTC);
      ld_ack_q    <= done_next_c && (done_client_c == C_LD);
      ul_ack_q    <= done_next_c && (done_client_c == C_UL);
      ul_rvalid_q <= done_next_c && (done_client_c == C_UL);
      unique case (state_q)
        S_IDLE: begin
          if (gnt_valid_c) begin
            client_q <= gnt_client_c;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
            if (gnt_client_c != C_RTC) begin
              last_ul_q <= (gnt_client_c == C_UL);
            end
            if (!gnt_in_range_c) begin
              state_q <= S_DONE;
              if (gnt_client_c == C_UL) begin
                ul_rdata_q <= 16'hFFFF;
              end
            end else if (gnt_client_c == C_UL) begin
              state_q   <= S_READ;
              bk_addr_q <= gnt_addr_c[AW-1:1];
            end else begin
              state_q   <= S_WRITE;
              bk_wr_q   <= 1'b1;
              bk_addr_q <= gnt_addr_c[AW-1:1];
              bk_data_q <= gnt_data_c;
            end
          end
        end
        S_WRITE: begin
          cnt_q <= cnt_q + 1'b1;
          if (done_next_c) begin
            bk_wr_q <= 1'b0;
            state_q <= S_DONE;
          end
        end
        S_READ: begin
          cnt_q <= cnt_q + 1'b1;
          if (done_next_c) begin
            ul_rdata_q <= bk_q;
            state_q    <= S_DONE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          bk_wr_q <= 1'b0;
        end
      endcase
    end
  end

  assign rtc_ack   = rtc_ack_q;
  assign ld_ack    = ld_ack_q;
  assign ul_ack    = ul_ack_q;
  assign ul_rvalid = ul_rvalid_q;
  assign ul_rdata  = ul_rdata_q;
  assign bk_wr     = bk_wr_q;
  assign bk_addr   = bk_addr_q;
  assign bk_data   = bk_data_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_save_ram_arbiter.sv
// Bench for save_ram_arbiter: vector table, reset/contention/zero-size sequences and random
// transactions checked against a transaction-level memory model.
module tb_save_ram_arbiter;

  localparam int RL  = 2;
  localparam int WH  = 3;
  localparam int RTC = 0;
  localparam int LD  = 1;
  localparam int UL  = 2;

  logic        clk_sys;
  logic        reset_n;
  logic [17:0] save_size_bytes;
  logic        rtc_req, ld_req, ul_req;
  logic [17:0] rtc_addr, ld_addr, ul_addr;
  logic [15:0] rtc_data, ld_data;
  logic        rtc_ack, ld_ack, ul_ack, ul_rvalid;
  logic [15:0] ul_rdata;
  logic        bk_wr;
  logic [16:0] bk_addr;
  logic [15:0] bk_data;
  logic [15:0] bk_q;
  logic        busy;

  int total = 0;
  int bad   = 0;

  save_ram_arbiter #(.READ_LATENCY(RL), .WR_HOLD(WH)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .save_size_bytes(save_size_bytes),
    .rtc_req(rtc_req), .rtc_addr(rtc_addr), .rtc_data(rtc_data), .rtc_ack(rtc_ack),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ack(ld_ack),
    .ul_req(ul_req), .ul_addr(ul_addr), .ul_ack(ul_ack), .ul_rvalid(ul_rvalid),
    .ul_rdata(ul_rdata), .bk_wr(bk_wr), .bk_addr(bk_addr), .bk_data(bk_data),
    .bk_q(bk_q), .busy(busy)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  // Power-up contents of the save RAM
  function automatic logic [15:0] init_word(input int w);
    if (w == 'h10) return 16'h1234;
    return 16'(w) ^ 16'hA5C3;
  endfunction

  // Save RAM with fixed read latency
  logic [15:0] ram   [131072];
  bit          ramv  [131072];
  logic [15:0] rpipe [RL];
  always @(posedge clk_sys) begin
    if (bk_wr === 1'b1) begin
      ram[bk_addr]  <= bk_data;
      ramv[bk_addr] <= 1'b1;
    end
    rpipe[0] <= ramv[bk_addr] ? ram[bk_addr] : init_word(int'(bk_addr));
    for (int i = 1; i < RL; i++) rpipe[i] <= rpipe[i-1];
  end
  assign bk_q = rpipe[RL-1];

  // Expected save contents, updated per completed in-range write
  logic [15:0] ref_mem [131072];
  bit          refv    [131072];
  function automatic logic [15:0] ref_rd(input int w);
    return refv[w] ? ref_mem[w] : init_word(w);
  endfunction
  function automatic void ref_wr(input int w, input logic [15:0] d);
    ref_mem[w] = d;
    refv[w]    = 1'b1;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_idle();
    int w = 0;
    while (busy !== 1'b0 && w < 32) begin
      @(negedge clk_sys);
      w++;
    end
    if (w >= 32) chk(busy === 1'b0, "idle wait timeout", 32'(busy), 0);
  endtask

  // One complete request/ack transaction from a single client
  task automatic txn(input int cli, input logic [17:0] addr, input logic [15:0] data,
                     input logic [17:0] size, input int exp_lat, input int exp_nwr,
                     input logic [16:0] exp_ba, input logic [15:0] exp_rd, input string nm);
    int k, nwr;
    bit got, bus_ok, other;
    wait_idle();
    save_size_bytes = size;
    case (cli)
      RTC: begin rtc_addr = addr; rtc_data = data; rtc_req = 1'b1; end
      LD:  begin ld_addr = addr; ld_data = data; ld_req = 1'b1; end
      default: begin ul_addr = addr; ul_req = 1'b1; end
    endcase
    k = 0; nwr = 0; got = 0; bus_ok = 1; other = 0;
    while (!got && k < 64) begin
      @(negedge clk_sys);
      k++;
      if (bk_wr === 1'b1) begin
        nwr++;
        if (bk_addr !== exp_ba || bk_data !== data) bus_ok = 0;
      end
      got = (cli == RTC) ? (rtc_ack === 1'b1) : (cli == LD) ? (ld_ack === 1'b1) : (ul_ack === 1'b1);
      if (cli == UL && !got && bk_addr !== exp_ba) bus_ok = 0;
      other = other | (cli != RTC && rtc_ack === 1'b1) | (cli != LD && ld_ack === 1'b1)
                    | (cli != UL && ul_ack === 1'b1);
    end
    rtc_req = 1'b0; ld_req = 1'b0; ul_req = 1'b0;
    chk(got && k == exp_lat, {nm, " ack latency"}, 32'(k), 32'(exp_lat));
    chk(nwr == exp_nwr, {nm, " bk_wr cycles"}, 32'(nwr), 32'(exp_nwr));
    if (exp_nwr > 0 || (cli == UL && exp_lat > 1))
      chk(bus_ok, {nm, " ram bus"}, 32'(bk_addr), 32'(exp_ba));
    chk(!other, {nm, " stray ack"}, 32'(other), 0);
    if (cli == UL) begin
      chk(ul_rvalid === 1'b1 && ul_rdata === exp_rd, {nm, " rdata"}, 32'(ul_rdata), 32'(exp_rd));
      @(negedge clk_sys);
      chk(ul_rvalid === 1'b0 && ul_rdata === exp_rd, {nm, " rdata hold"}, 32'(ul_rdata), 32'(exp_rd));
    end else begin
      chk(ul_rvalid === 1'b0, {nm, " rvalid on write"}, 32'(ul_rvalid), 0);
    end
  endtask

  typedef struct {
    int          cli;
    logic [17:0] addr;
    logic [15:0] data;
    logic [17:0] size;
    int          exp_lat;
    int          exp_nwr;
    logic [16:0] exp_ba;
    logic [15:0] exp_rd;
  } vec_t;

  function automatic vec_t mkv(input int cli, input logic [17:0] addr, input logic [15:0] data,
                               input logic [17:0] size, input int lat, input int nwr,
                               input logic [16:0] ba, input logic [15:0] rd);
    vec_t v;
    v.cli = cli; v.addr = addr; v.data = data; v.size = size;
    v.exp_lat = lat; v.exp_nwr = nwr; v.exp_ba = ba; v.exp_rd = rd;
    return v;
  endfunction

  initial begin
    vec_t vecs[$];
    int   seen[$];
    int   exp_order[7];
    int   cyc, nack, nld;
    bit   ld_pend, ul_pend;

    vecs.push_back(mkv(LD,  18'h00102, 16'hBEEF, 18'd8192, 4, 3, 17'h00081, 16'h0000));
    vecs.push_back(mkv(UL,  18'h00020, 16'h0000, 18'd8192, 4, 0, 17'h00010, 16'h1234));
    vecs.push_back(mkv(UL,  18'h00103, 16'h0000, 18'd8192, 4, 0, 17'h00081, 16'hBEEF));
    vecs.push_back(mkv(UL,  18'h00200, 16'h0000, 18'd512,  1, 0, 17'h00000, 16'hFFFF));
    vecs.push_back(mkv(LD,  18'h00300, 16'h1111, 18'd512,  1, 0, 17'h00000, 16'h0000));
    vecs.push_back(mkv(RTC, 18'h001FF, 16'hCAFE, 18'd512,  4, 3, 17'h000FF, 16'h0000));
    vecs.push_back(mkv(UL,  18'h001FE, 16'h0000, 18'd512,  4, 0, 17'h000FF, 16'hCAFE));
    vecs.push_back(mkv(LD,  18'h001FF, 16'h2222, 18'h001FF, 1, 0, 17'h00000, 16'h0000));
    vecs.push_back(mkv(UL,  18'h001FE, 16'h0000, 18'h001FF, 4, 0, 17'h000FF, 16'hCAFE));
    vecs.push_back(mkv(RTC, 18'h00000, 16'h3333, 18'd0,    1, 0, 17'h00000, 16'h0000));
    vecs.push_back(mkv(UL,  18'h3FFFE, 16'h0000, 18'h3FFFF, 4, 0, 17'h1FFFF, 16'h5A3C));
    vecs.push_back(mkv(UL,  18'h00000, 16'h0000, 18'd0,    1, 0, 17'h00000, 16'hFFFF));
    exp_order = '{RTC, LD, UL, LD, UL, LD, UL};

    reset_n = 1'b0; save_size_bytes = '0;
    rtc_req = 0; ld_req = 0; ul_req = 0;
    rtc_addr = '0; ld_addr = '0; ul_addr = '0; rtc_data = '0; ld_data = '0;
    repeat (3) @(negedge clk_sys);
    chk({rtc_ack, ld_ack, ul_ack, ul_rvalid} === 4'b0, "reset acks", 32'({rtc_ack, ld_ack, ul_ack, ul_rvalid}), 0);
    chk(bk_wr === 1'b0 && busy === 1'b0, "reset bk_wr/busy", 32'({bk_wr, busy}), 0);
    chk(bk_addr === '0 && bk_data === '0, "reset ram bus", 32'({bk_addr, bk_data}), 0);
    chk(ul_rdata === '0, "reset rdata", 32'(ul_rdata), 0);
    reset_n = 1'b1;
    @(negedge clk_sys);

    foreach (vecs[i]) begin
      txn(vecs[i].cli, vecs[i].addr, vecs[i].data, vecs[i].size, vecs[i].exp_lat,
          vecs[i].exp_nwr, vecs[i].exp_ba, vecs[i].exp_rd, $sformatf("vec%0d", i));
      if (vecs[i].cli != UL && vecs[i].addr < vecs[i].size)
        ref_wr(int'(vecs[i].addr >> 1), vecs[i].data);
    end

    // Reset during the second bk_wr cycle of a loader write
    wait_idle();
    save_size_bytes = 18'd8192; ld_addr = 18'h00400; ld_data = 16'h5555; ld_req = 1'b1;
    @(negedge clk_sys);
    chk(bk_wr === 1'b1, "rst-mid-write 1st wr cycle", 32'(bk_wr), 1);
    @(negedge clk_sys);
    chk(bk_wr === 1'b1, "rst-mid-write 2nd wr cycle", 32'(bk_wr), 1);
    reset_n = 1'b0; ld_req = 1'b0;
    @(negedge clk_sys);
    chk(bk_wr === 1'b0 && busy === 1'b0, "rst-mid-write bk_wr/busy", 32'({bk_wr, busy}), 0);
    reset_n = 1'b1;
    ref_wr('h200, 16'h5555);
    nld = 0;
    repeat (8) begin
      @(negedge clk_sys);
      if (ld_ack === 1'b1) nld++;
    end
    chk(nld == 0, "rst-mid-write ld_ack count", 32'(nld), 0);

    // Three-way contention straight after reset; rtc requests once, ld/ul re-request
    save_size_bytes = 18'd8192;
    rtc_addr = 18'h10; rtc_data = 16'h7777; ld_addr = 18'h20; ld_data = 16'h8888; ul_addr = 18'h30;
    rtc_req = 1; ld_req = 1; ul_req = 1; ld_pend = 0; ul_pend = 0; cyc = 0;
    while (seen.size() < 7 && cyc < 300) begin
      @(negedge clk_sys);
      cyc++;
      if (ld_pend) begin ld_req = 1; ld_pend = 0; end
      if (ul_pend) begin ul_req = 1; ul_pend = 0; end
      nack = int'(rtc_ack) + int'(ld_ack) + int'(ul_ack);
      if (nack != 0) chk(nack == 1, "contention single ack", 32'(nack), 1);
      if (rtc_ack === 1'b1) begin seen.push_back(RTC); rtc_req = 0; end
      if (ld_ack === 1'b1) begin seen.push_back(LD); ld_req = 0; ld_pend = 1; end
      if (ul_ack === 1'b1) begin seen.push_back(UL); ul_req = 0; ul_pend = 1; end
    end
    rtc_req = 0; ld_req = 0; ul_req = 0;
    chk(seen.size() == 7, "contention ack count", 32'(seen.size()), 7);
    for (int i = 0; i < seen.size() && i < 7; i++)
      chk(seen[i] == exp_order[i], $sformatf("contention grant %0d", i), 32'(seen[i]), 32'(exp_order[i]));
    ref_wr('h08, 16'h7777);
    ref_wr('h10, 16'h8888);

    txn(LD, 18'h00402, 16'h6666, 18'd8192, WH + 1, WH, 17'h00201, 16'h0, "post-reset ld write");
    ref_wr('h201, 16'h6666);
    txn(UL, 18'h00400, 16'h0, 18'd8192, RL + 2, 0, 17'h00200, 16'h5555, "post-reset ul read");

    // Zero-size save region: every RTC write is dropped but still acknowledged
    for (int i = 0; i < 5; i++)
      txn(RTC, 18'(2 * i), 16'(16'hA000 + i), 18'd0, 1, 0, 17'h0, 16'h0, $sformatf("size0 rtc%0d", i));

    // Random single-client traffic against the memory model
    for (int n = 0; n < 80; n++) begin
      int          cli, sel, lat, nwr;
      logic [17:0] a, sz;
      logic [15:0] d, rd;
      bit          inr;
      cli = $urandom_range(0, 2);
      a   = 18'($urandom_range(0, 1023));
      d   = 16'($urandom);
      sel = $urandom_range(0, 3);
      sz  = (sel == 0) ? 18'd0 : (sel == 1) ? 18'd256 : (sel == 2) ? 18'd1024 : 18'($urandom_range(0, 1100));
      inr = (a < sz);
      lat = !inr ? 1 : (cli == UL) ? RL + 2 : WH + 1;
      nwr = (inr && cli != UL) ? WH : 0;
      rd  = inr ? ref_rd(int'(a >> 1)) : 16'hFFFF;
      txn(cli, a, d, sz, lat, nwr, 17'(a >> 1), rd, $sformatf("rand%0d", n));
      if (inr && cli != UL) ref_wr(int'(a >> 1), d);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk_sys);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
